// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and result flag bundle.
// Codes 0-3 match the original 2-bit opcode enum.
package alu_pkg;

    typedef enum bit [2:0] {
        OpAdd = 3'd0,
        OpSub = 3'd1,
        OpMul = 3'd2,
        OpXor = 3'd3,
        OpAnd = 3'd4,
        OpOr  = 3'd5,
        OpShl = 3'd6,
        OpShr = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: maps (a, b, op) to a 2*WIDTH result and status flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  alu_op_e            i_op,
    output logic [2*WIDTH-1:0] o_result,
    output alu_flags_t         o_flags
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_sh;
    logic             w_legal;

    always_comb begin
        w_sum    = {1'b0, i_a} + {1'b0, i_b};
        w_diff   = {1'b0, i_a} - {1'b0, i_b};
        w_sh     = i_b[SHW-1:0];
        w_legal  = 1'b1;
        o_result = '0;
        o_flags  = '0;
        case (i_op)
            OpAdd: begin
                o_result      = {{(WIDTH-1){1'b0}}, w_sum};
                o_flags.carry = w_sum[WIDTH];
                o_flags.ovf   = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                                (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OpSub: begin
                // Top bit of the widened difference is the borrow, i.e. a < b.
                o_result      = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
                o_flags.carry = w_diff[WIDTH];
                o_flags.ovf   = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                                (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OpMul: o_result = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
            OpXor: o_result = {{WIDTH{1'b0}}, i_a ^ i_b};
            OpAnd: o_result = {{WIDTH{1'b0}}, i_a & i_b};
            OpOr:  o_result = {{WIDTH{1'b0}}, i_a | i_b};
            OpShl: o_result = {{WIDTH{1'b0}}, i_a} << w_sh;
            OpShr: o_result = {{WIDTH{1'b0}}, i_a >> w_sh};
            default: w_legal = 1'b0;
        endcase
        o_flags.zero = w_legal && (o_result == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes, delivery counter and sticky overflow.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  alu_op_e            op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               flag_zero,
    output logic               flag_carry,
    output logic               flag_ovf,
    output logic               ovf_sticky,
    input  logic               ovf_clr,
    output logic [CNT_W-1:0]   txn_count
);

    logic               r_s1_valid;
    logic [WIDTH-1:0]   r_s1_a;
    logic [WIDTH-1:0]   r_s1_b;
    alu_op_e            r_s1_op;
    logic               r_s2_valid;
    logic [2*WIDTH-1:0] r_s2_result;
    alu_flags_t         r_s2_flags;
    logic               r_ovf_sticky;
    logic [CNT_W-1:0]   r_txn_count;

    logic               w_adv1;
    logic               w_adv2;
    logic               w_deliver;
    logic [2*WIDTH-1:0] w_result;
    alu_flags_t         w_flags;

    assign w_adv2    = !r_s2_valid || out_ready;
    assign w_adv1    = !r_s1_valid || w_adv2;
    assign w_deliver = r_s2_valid && out_ready;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a      (r_s1_a),
        .i_b      (r_s1_b),
        .i_op     (r_s1_op),
        .o_result (w_result),
        .o_flags  (w_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= OpAdd;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a  <= a;
                r_s1_b  <= b;
                r_s1_op <= op;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_flags  <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_result <= w_result;
                r_s2_flags  <= w_flags;
            end
        end
    end

    // A setting delivery takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
            r_txn_count  <= '0;
        end else begin
            if (w_deliver && r_s2_flags.ovf) begin
                r_ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf_sticky <= 1'b0;
            end
            if (w_deliver) begin
                r_txn_count <= r_txn_count + 1'b1;
            end
        end
    end

    assign in_ready   = w_adv1;
    assign out_valid  = r_s2_valid;
    assign result     = r_s2_result;
    assign flag_zero  = r_s2_flags.zero;
    assign flag_carry = r_s2_flags.carry;
    assign flag_ovf   = r_s2_flags.ovf;
    assign ovf_sticky = r_ovf_sticky;
    assign txn_count  = r_txn_count;

endmodule
